qdr_user_arb: RTL
=================

Name: qdr_user_arb

Overview:
- Shares the single QDRII+ MIG user interface between NUM_REQ independent requesters. Each requester has its own write and read request channels.
- Sits between client logic and the memory controller in the same clock domain, above the clock/reset infrastructure.
- Write and read ports are arbitrated independently with round-robin fairness, because QDR has separate read and write paths.
- Read returns are routed back to the issuing requester through an in-order tag FIFO.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_WIDTH, 18: QDR address width.
- DATA_WIDTH, 36: QDR device data width.
- BW_WIDTH, 4: byte-write lanes per beat.
- BURST_LEN, 4: beats per user transaction. User data width UW = DATA_WIDTH*BURST_LEN; user byte-write width UB = BW_WIDTH*BURST_LEN.
- TAG_DEPTH, 16: maximum outstanding reads (power of 2).

Ports:
- sys_clk  in  1  user-side clock.
- sys_rst  in  1  synchronous, active-high reset.
- cal_done  in  1  calibration complete from controller; nothing is issued while low.
- wr_valid  in  NUM_REQ  per-requester write request.
- wr_ready  out  NUM_REQ  write accepted this cycle.
- wr_addr  in  NUM_REQ*ADDR_WIDTH  flattened write addresses.
- wr_data  in  NUM_REQ*UW  flattened write data.
- wr_bw_n  in  NUM_REQ*UB  flattened byte-write enables, active low.
- rd_valid  in  NUM_REQ  per-requester read request.
- rd_ready  out  NUM_REQ  read accepted this cycle.
- rd_addr  in  NUM_REQ*ADDR_WIDTH  flattened read addresses.
- rsp_valid  out  NUM_REQ  one-hot read data return.
- rsp_data  out  UW  read data, shared by all requesters.
- app_wr_cmd  out  1  controller write command.
- app_wr_addr  out  ADDR_WIDTH  controller write address.
- app_wr_data  out  UW  controller write data.
- app_wr_bw_n  out  UB  controller byte-write enables.
- app_rd_cmd  out  1  controller read command.
- app_rd_addr  out  ADDR_WIDTH  controller read address.
- app_rd_valid  in  1  controller read data valid.
- app_rd_data  in  UW  controller read data.
- rsp_err  out  1  sticky: read data arrived with no outstanding tag.

Behaviour:
- Reset values: all app_* outputs 0, except app_wr_bw_n which resets to all-ones. rsp_valid=0, rsp_data=0, rsp_err=0. Both round-robin pointers reset to 0. Tag FIFO empty; outstanding count 0.

Write arbitration:
- Combinational grant. Scan from wr_ptr upward with wrap and grant the first i with wr_valid[i].
- wr_ready[i] = grant[i] & cal_done. At most one bit is set. The controller accepts a command every cycle, so there is no backpressure from it.
- On accept: app_wr_cmd/addr/data/bw_n are registered from requester i (1-cycle latency), and wr_ptr <= (i+1) mod NUM_REQ.
- With no accept, app_wr_cmd=0 and the other app_wr_* fields hold their values.

Read arbitration:
- Same scheme using rd_ptr.
- rd_ready[i] additionally requires tag FIFO not full, i.e. outstanding < TAG_DEPTH.
- On accept: app_rd_cmd/addr are registered, and requester index i is pushed into the tag FIFO (width clog2(NUM_REQ), min 1).

Response path:
- On app_rd_valid: pop the FIFO head h. Next cycle rsp_valid = one-hot(h) and rsp_data = app_rd_data. Latency is 1 cycle.
- If app_rd_valid arrives while the FIFO is empty: set rsp_err, drive rsp_valid=0, and leave the FIFO unchanged.
- Simultaneous push and pop in the same cycle is legal, including when the FIFO is full: the pop frees the slot in the same cycle, so a full FIFO plus app_rd_valid allows a read grant.

cal_done:
- cal_done low forces all ready=0.
- cal_done falling mid-operation: in-flight responses still drain normally.

sys_rst mid-operation:
- Clears the FIFO and pointers; responses returning afterwards set rsp_err.

Optional Feature:
- QDR_USER_ARB_STATS_EN defined:
  - Adds per-requester 32-bit wr_cnt and rd_cnt, exposed flattened as output stat_wr_cnt/stat_rd_cnt [NUM_REQ*32].
  - Counters increment on accept, wrap at 2^32, and clear on sys_rst.
  - Adds output stat_max_outstanding [clog2(TAG_DEPTH)+1], a high-water mark of the outstanding count.
- Undefined: these ports and this logic are absent.

Decomposition:
- Package qdr_arb_pkg holds:
  - the function clog2;
  - the round-robin helper function rr_pick(valid, ptr), which returns a one-hot grant;
  - the constants UW/UB derivation.
- Sub-module qdr_tag_fifo: synchronous FIFO with parameters WIDTH and DEPTH, providing push, pop, full, empty and count. It is instantiated once for read tags.

Test Plan:
- Hold cal_done=0 with all valids asserted for 20 cycles -> ready all 0, app_wr_cmd=app_rd_cmd=0. Then raise cal_done -> requester 0 is granted on that cycle.
- NUM_REQ=2, both wr_valid held high for 8 cycles -> grants alternate 0,1,0,1. app_wr_addr matches each granted requester one cycle after its wr_ready.
- Requester 1 issues reads to 0x100 and 0x101, then requester 0 to 0x200. Return 3 app_rd_valid beats with data A,B,C -> rsp_valid sequence 10,10,01 with rsp_data A,B,C.
- Issue 16 reads without any returns -> the 17th rd_valid sees rd_ready=0. Pulse app_rd_valid in the same cycle as the 17th request -> that request is granted.
- Pulse app_rd_valid with the FIFO empty -> rsp_err=1 and stays 1 until sys_rst; rsp_valid stays 0.
- Assert sys_rst for 1 cycle with 5 reads outstanding -> all outputs return to reset values and both pointers go to 0. The next request from requester 0 is granted first.

Source files
------------

// File: rtl/qdr_arb_pkg.sv
// qdr_arb_pkg: shared helpers for the QDR user-port arbiter (clog2, round-robin pick, user widths)
package qdr_arb_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int user_w(input int beat_w, input int burst);
    return beat_w * burst;
  endfunction
  // One-hot grant of the first valid at or above ptr, wrapping modulo n (n <= 8).
  function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
    logic [7:0] g;
    g = '0;
    for (int k = 7; k >= 0; k--)
      if (k < n && valid[(int'(ptr) + k) % n]) g = 8'(1) << ((int'(ptr) + k) % n);
    return g;
  endfunction
endpackage

// File: rtl/qdr_tag_fifo.sv
// qdr_tag_fifo: synchronous FIFO; push and pop may coincide even when full
module qdr_tag_fifo import qdr_arb_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/qdr_user_arb.sv
// qdr_user_arb: round-robin sharing of the QDRII+ user port; QDR_USER_ARB_STATS_EN adds accept counters
module qdr_user_arb import qdr_arb_pkg::*; #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int BURST_LEN  = 4,
  parameter int TAG_DEPTH  = 16,
  localparam int UW = user_w(DATA_WIDTH, BURST_LEN),
  localparam int UB = user_w(BW_WIDTH, BURST_LEN)
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          cal_done,
  input  logic [NUM_REQ-1:0]            wr_valid,
  output logic [NUM_REQ-1:0]            wr_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*UW-1:0]         wr_data,
  input  logic [NUM_REQ*UB-1:0]         wr_bw_n,
  input  logic [NUM_REQ-1:0]            rd_valid,
  output logic [NUM_REQ-1:0]            rd_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [UW-1:0]                 rsp_data,
  output logic                          app_wr_cmd,
  output logic [ADDR_WIDTH-1:0]         app_wr_addr,
  output logic [UW-1:0]                 app_wr_data,
  output logic [UB-1:0]                 app_wr_bw_n,
  output logic                          app_rd_cmd,
  output logic [ADDR_WIDTH-1:0]         app_rd_addr,
  input  logic                          app_rd_valid,
  input  logic [UW-1:0]                 app_rd_data,
  output logic                          rsp_err
`ifdef QDR_USER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         stat_wr_cnt,
  output logic [NUM_REQ*32-1:0]         stat_rd_cnt,
  output logic [clog2(TAG_DEPTH):0]     stat_max_outstanding
`endif
);
  localparam int TW = clog2(NUM_REQ) > 1 ? clog2(NUM_REQ) : 1;
  logic [TW-1:0] wr_ptr, rd_ptr, wr_idx, rd_idx, tag_head;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic wr_acc, rd_acc, tag_pop, tag_full, tag_empty;
  logic [clog2(TAG_DEPTH):0] tag_count;
  assign wr_gnt = NUM_REQ'(rr_pick(8'(wr_valid), 3'(wr_ptr), NUM_REQ));
  assign rd_gnt = NUM_REQ'(rr_pick(8'(rd_valid), 3'(rd_ptr), NUM_REQ));
  always_comb begin
    wr_idx = '0;
    rd_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wr_gnt[k]) wr_idx = TW'(k);
      if (rd_gnt[k]) rd_idx = TW'(k);
    end
  end
  assign tag_pop = app_rd_valid & ~tag_empty;
  // A concurrent return frees a slot, so a full tag FIFO can still take a read.
  assign wr_ready = cal_done ? wr_gnt : '0;
  assign rd_ready = (cal_done & (~tag_full | app_rd_valid)) ? rd_gnt : '0;
  assign wr_acc = |wr_ready;
  assign rd_acc = |rd_ready;
  qdr_tag_fifo #(.WIDTH(TW), .DEPTH(TAG_DEPTH)) u_tags (
    .clk(sys_clk), .rst(sys_rst), .push(rd_acc), .pop(tag_pop), .din(rd_idx),
    .dout(tag_head), .full(tag_full), .empty(tag_empty), .count(tag_count)
  );
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      app_wr_cmd <= 1'b0;
      app_wr_addr <= '0;
      app_wr_data <= '0;
      app_wr_bw_n <= '1;
      app_rd_cmd <= 1'b0;
      app_rd_addr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      app_wr_cmd <= wr_acc;
      if (wr_acc) begin
        app_wr_addr <= wr_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
        app_wr_data <= wr_data[wr_idx*UW +: UW];
        app_wr_bw_n <= wr_bw_n[wr_idx*UB +: UB];
        wr_ptr <= (wr_idx == TW'(NUM_REQ-1)) ? '0 : wr_idx + 1'b1;
      end
      app_rd_cmd <= rd_acc;
      if (rd_acc) begin
        app_rd_addr <= rd_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
        rd_ptr <= (rd_idx == TW'(NUM_REQ-1)) ? '0 : rd_idx + 1'b1;
      end
      rsp_valid <= tag_pop ? NUM_REQ'(1) << tag_head : '0;
      if (tag_pop) rsp_data <= app_rd_data;
      if (app_rd_valid & tag_empty) rsp_err <= 1'b1;
    end
  end
`ifdef QDR_USER_ARB_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
      stat_max_outstanding <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (wr_ready[k]) stat_wr_cnt[k*32 +: 32] <= stat_wr_cnt[k*32 +: 32] + 32'd1;
        if (rd_ready[k]) stat_rd_cnt[k*32 +: 32] <= stat_rd_cnt[k*32 +: 32] + 32'd1;
      end
      stat_max_outstanding <= (tag_count > stat_max_outstanding) ? tag_count : stat_max_outstanding;
    end
  end
`endif
endmodule
